omem_write_arbiter: RTL and testbench

Shares one external output-memory (OMEM) write port between NUM_VP vector processors. Each VP emits fire-and-forget OMEM writes (WE pulse plus address and data, with no backpressure). The arbiter buffers each VP's writes in a private FIFO and drains them round-robin onto a Wishbone-style single-master write bus. It sits at top level between the VP array's OMEM_WE/OMEM_ADDR/OMEM_DATA outputs and the OMEM slave.

---
 rtl/omem_write_arbiter_pkg.sv | 13 +
 rtl/omem_write_fifo.sv | 37 +++
 rtl/omem_write_arbiter.sv | 101 ++++++++++
 tb/tb_omem_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/omem_write_arbiter_pkg.sv
// omem_write_arbiter_pkg: shared FSM encoding and sizing helpers for the OMEM write arbiter
package omem_write_arbiter_pkg;
    typedef enum logic {IDLE, XFER} state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
    function automatic int entry_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction
endpackage

// File: rtl/omem_write_fifo.sv
// omem_write_fifo: single-clock show-ahead FIFO; a push into a full FIFO is accepted only with a same-edge pop
module omem_write_fifo import omem_write_arbiter_pkg::*; #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign empty = cnt == '0;
    assign full = cnt == (AW+1)'(DEPTH);
    assign head = mem[rd];
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            cnt <= '0;
        end else begin
            rd <= rd + AW'(do_pop);
            wr <= wr + AW'(do_push);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wr] <= din;
endmodule

// File: rtl/omem_write_arbiter.sv
// omem_write_arbiter: round-robin drain of per-VP OMEM write FIFOs onto one Wishbone write master.
// Define OMEM_ARB_BURST_EN to let a VP keep the bus for up to BURST_MAX consecutive writes.
module omem_write_arbiter import omem_write_arbiter_pkg::*; #(
    parameter int NUM_VP = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_VP-1:0]          iVpOmemWe,
    input  logic [NUM_VP*ADDR_W-1:0]   iVpOmemAddr,
    input  logic [NUM_VP*DATA_W-1:0]   iVpOmemData,
    output logic [ADDR_W-1:0]          OMEM_ADR_O,
    output logic [DATA_W-1:0]          OMEM_DAT_O,
    output logic                       OMEM_WE_O,
    output logic                       OMEM_STB_O,
    output logic                       OMEM_CYC_O,
    input  logic                       OMEM_ACK_I,
    output logic [clog2(NUM_VP)-1:0]   oGrantId,
    output logic [NUM_VP-1:0]          oOverflow,
    output logic                       oIdle
);
    localparam int GW = clog2(NUM_VP);
    localparam int EW = entry_w(ADDR_W, DATA_W);
`ifdef OMEM_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    // A limit of one makes the regrant test always false: strict round-robin
    localparam int BURST_LIM = BURST_EN ? BURST_MAX : 1;
    localparam int BW = clog2(BURST_LIM + 1);
    state_t state, state_n;
    logic [GW-1:0] ptr, ptr_n, base, sel, idx;
    logic [BW-1:0] burst, burst_n;
    logic [NUM_VP-1:0] full, empty, pop;
    logic [EW-1:0] head [NUM_VP];
    logic any, load, regrant;
    for (genvar i = 0; i < NUM_VP; i++) begin : g_fifo
        omem_write_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(Clock),
            .rst(Reset),
            .push(iVpOmemWe[i]),
            .pop(pop[i]),
            .din({iVpOmemAddr[i*ADDR_W +: ADDR_W], iVpOmemData[i*DATA_W +: DATA_W]}),
            .head(head[i]),
            .full(full[i]),
            .empty(empty[i])
        );
    end
    always_comb begin
        any = ~&empty;
        base = state == XFER ? (oGrantId == GW'(NUM_VP - 1) ? '0 : oGrantId + GW'(1)) : ptr;
        sel = base;
        idx = '0;
        for (int k = NUM_VP - 1; k >= 0; k--) begin
            idx = GW'(int'(base) + k >= NUM_VP ? int'(base) + k - NUM_VP : int'(base) + k);
            sel = empty[idx] ? sel : idx;
        end
        regrant = state == XFER && !empty[oGrantId] && burst < BW'(BURST_LIM);
        sel = regrant ? oGrantId : sel;
        load = any && (state == IDLE || OMEM_ACK_I);
        burst_n = (state == XFER && sel == oGrantId) ? (burst == BW'(BURST_LIM) ? burst : burst + BW'(1)) : BW'(1);
        ptr_n = (state == XFER && OMEM_ACK_I && !regrant) ? base : ptr;
        state_n = state == IDLE ? (any ? XFER : IDLE) : (OMEM_ACK_I && !any ? IDLE : XFER);
        pop = load ? NUM_VP'(1) << sel : '0;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            ptr <= '0;
            burst <= '0;
            oGrantId <= '0;
            oOverflow <= '0;
            OMEM_ADR_O <= '0;
            OMEM_DAT_O <= '0;
            OMEM_STB_O <= 1'b0;
            OMEM_CYC_O <= 1'b0;
            OMEM_WE_O <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            oOverflow <= oOverflow | (iVpOmemWe & full & ~pop);
            if (load) begin
                {OMEM_ADR_O, OMEM_DAT_O} <= head[sel];
                oGrantId <= sel;
                burst <= burst_n;
                OMEM_STB_O <= 1'b1;
                OMEM_CYC_O <= 1'b1;
                OMEM_WE_O <= 1'b1;
            end else if (state == XFER && OMEM_ACK_I) begin
                OMEM_STB_O <= 1'b0;
                OMEM_CYC_O <= 1'b0;
                OMEM_WE_O <= 1'b0;
            end
        end
    end
    assign oIdle = state == IDLE && &empty;
endmodule

// File: tb/tb_omem_write_arbiter.sv
// tb_omem_write_arbiter: directed-vector bench for omem_write_arbiter (4 VPs, depth 4, BURST_MAX 2)
module tb_omem_write_arbiter;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic [3:0] we;
    logic [127:0] addr, data;
    logic [31:0] adr, dat;
    logic we_o, stb, cyc, ack, ack_auto, ack_man, idle;
    logic [1:0] grant;
    logic [3:0] ovf;
    int total = 0;
    int bad = 0;
`ifdef OMEM_ARB_BURST_EN
    logic [1:0] exp_g [3] = '{2'd0, 2'd1, 2'd0};
    logic [31:0] exp_a [3] = '{32'h501, 32'h510, 32'h502};
`else
    logic [1:0] exp_g [3] = '{2'd1, 2'd0, 2'd0};
    logic [31:0] exp_a [3] = '{32'h510, 32'h501, 32'h502};
`endif
    assign ack = ack_auto ? stb : ack_man;
    always #5 Clock = ~Clock;
    omem_write_arbiter #(.NUM_VP(4), .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .BURST_MAX(2)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iVpOmemWe(we),
        .iVpOmemAddr(addr),
        .iVpOmemData(data),
        .OMEM_ADR_O(adr),
        .OMEM_DAT_O(dat),
        .OMEM_WE_O(we_o),
        .OMEM_STB_O(stb),
        .OMEM_CYC_O(cyc),
        .OMEM_ACK_I(ack),
        .oGrantId(grant),
        .oOverflow(ovf),
        .oIdle(idle)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask
    task automatic push(input int i, input logic [31:0] a, input logic [31:0] d);
        we[i] = 1'b1;
        addr[i*32 +: 32] = a;
        data[i*32 +: 32] = d;
    endtask
    task automatic apply_reset();
        Reset = 1'b1;
        we = '0;
        ack_auto = 1'b1;
        ack_man = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask
    initial begin
        we = '0;
        addr = '0;
        data = '0;
        ack_auto = 1'b1;
        ack_man = 1'b0;
        tick();
        tick();
        check("rst_stb", stb, 0);
        check("rst_cyc", cyc, 0);
        check("rst_we", we_o, 0);
        check("rst_adr", adr, 0);
        check("rst_dat", dat, 0);
        check("rst_grant", grant, 0);
        check("rst_ovf", ovf, 0);
        check("rst_idle", idle, 1);
        Reset = 1'b0;
        // single write from VP2
        push(2, 32'h100, 32'hDEADBEEF);
        tick();
        we = '0;
        check("single_stb_early", stb, 0);
        check("single_busy", idle, 0);
        tick();
        check("single_stb", stb, 1);
        check("single_cyc", cyc, 1);
        check("single_we", we_o, 1);
        check("single_adr", adr, 32'h100);
        check("single_dat", dat, 32'hDEADBEEF);
        check("single_grant", grant, 2);
        tick();
        check("single_stb_done", stb, 0);
        check("single_idle", idle, 1);
        // all four VPs at once, zero-wait slave
        apply_reset();
        for (int i = 0; i < 4; i++) push(i, 32'h200 + i, 32'hA0 + i);
        tick();
        we = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_grant", grant, k);
            check("rr_adr", adr, 32'h200 + k);
            check("rr_stb", stb, 1);
        end
        tick();
        check("rr_stb_done", stb, 0);
        check("rr_idle", idle, 1);
        // wait states with VP1 arriving during the stall
        apply_reset();
        ack_auto = 1'b0;
        push(0, 32'h300, 32'h33);
        tick();
        we = '0;
        tick();
        check("ws_grant0", grant, 0);
        push(1, 32'h301, 32'h44);
        for (int k = 0; k < 3; k++) begin
            tick();
            we = '0;
            check("ws_stb_hold", stb, 1);
            check("ws_adr_hold", adr, 32'h300);
            check("ws_dat_hold", dat, 32'h33);
        end
        ack_man = 1'b1;
        tick();
        check("ws_next_grant", grant, 1);
        check("ws_next_adr", adr, 32'h301);
        check("ws_next_stb", stb, 1);
        tick();
        ack_man = 1'b0;
        check("ws_stb_done", stb, 0);
        check("ws_idle", idle, 1);
        // overflow on VP0 with the slave stalled
        apply_reset();
        ack_auto = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push(0, 32'h400 + k, k);
            tick();
            if (k == 4) check("ovf_before", ovf, 0);
        end
        we = '0;
        check("ovf_set", ovf, 4'b0001);
        check("ovf_head", adr, 32'h400);
        ack_auto = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("ovf_drain_adr", adr, 32'h400 + k);
        end
        tick();
        check("ovf_drain_done", stb, 0);
        check("ovf_sticky", ovf, 4'b0001);
        apply_reset();
        check("ovf_cleared", ovf, 0);
        // burst versus strict round-robin
        ack_auto = 1'b0;
        push(0, 32'h500, 1);
        push(1, 32'h510, 2);
        tick();
        we = '0;
        push(0, 32'h501, 3);
        tick();
        check("burst_first_grant", grant, 0);
        check("burst_first_adr", adr, 32'h500);
        push(0, 32'h502, 4);
        tick();
        we = '0;
        ack_auto = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("burst_grant", grant, exp_g[k]);
            check("burst_adr", adr, exp_a[k]);
        end
        tick();
        check("burst_done", stb, 0);
        // reset in the middle of a transfer
        apply_reset();
        ack_auto = 1'b0;
        push(0, 32'h600, 5);
        push(3, 32'h630, 6);
        tick();
        we = '0;
        tick();
        check("mid_stb", stb, 1);
        Reset = 1'b1;
        tick();
        check("mid_rst_stb", stb, 0);
        check("mid_rst_cyc", cyc, 0);
        check("mid_rst_idle", idle, 1);
        Reset = 1'b0;
        ack_auto = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mid_quiet_stb", stb, 0);
        end
        check("mid_quiet_idle", idle, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
